// File: rtl/c7bexu_lsu_ctl_if.sv
// Handshake bundle between the execute pipeline and the LSU/CSR sequencing controller.
// The controller connects through the slave view; the pipeline side uses master.
interface c7bexu_lsu_ctl_if;
  logic       flush;
  logic       lsu_vld_e;
  logic       csr_vld_e;
  logic       lsu_except_ale_ls1;
  logic       lsu_except_buserr_ls3;
  logic       lsu_except_ecc_ls3;
  logic       lsu_data_valid_ls3;
  logic       lsu_wr_fin_ls3;
  logic       stall;
  logic       lsu_busy;
  logic       lsu_done;
  logic       except_vld;
  logic [1:0] except_code;
  logic       req_conflict;

  modport master (
    output flush, lsu_vld_e, csr_vld_e, lsu_except_ale_ls1, lsu_except_buserr_ls3,
           lsu_except_ecc_ls3, lsu_data_valid_ls3, lsu_wr_fin_ls3,
    input  stall, lsu_busy, lsu_done, except_vld, except_code, req_conflict
  );

  modport slave (
    input  flush, lsu_vld_e, csr_vld_e, lsu_except_ale_ls1, lsu_except_buserr_ls3,
           lsu_except_ecc_ls3, lsu_data_valid_ls3, lsu_wr_fin_ls3,
    output stall, lsu_busy, lsu_done, except_vld, except_code, req_conflict
  );
endinterface

// File: rtl/c7bexu_lsu_ctl.sv
// LSU / CSR sequencing controller: tracks one outstanding load/store through LS1 and WAIT,
// resolves completion versus exceptions, times out stuck accesses and stalls for CSR ops.
module c7bexu_lsu_ctl #(
  parameter int TIMEOUT   = 255,
  parameter int CSR_STALL = 2
) (
  input logic              clk,
  input logic              resetn,
  c7bexu_lsu_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LS1  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CSR  = 2'd3
  } state_t;

  localparam logic [1:0] CODE_ALE    = 2'd0;
  localparam logic [1:0] CODE_BUSERR = 2'd1;
  localparam logic [1:0] CODE_ECC    = 2'd2;
  localparam logic [1:0] CODE_TMO    = 2'd3;
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [1:0] CSR_LOAD    = 2'(CSR_STALL - 1);

  state_t     state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [1:0] csr_cnt_q, csr_cnt_d;
  logic       stall_q, stall_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       exc_q, exc_d;
  logic [1:0] code_q, code_d;
  logic       conflict_q, conflict_d;
  logic       cmpl_s;

  assign cmpl_s = bus.lsu_data_valid_ls3 | bus.lsu_wr_fin_ls3;

  // Next-state, counter and pulse decode; flush overrides every concurrent event.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    csr_cnt_d  = csr_cnt_q;
    done_d     = 1'b0;
    exc_d      = 1'b0;
    code_d     = 2'd0;
    conflict_d = 1'b0;
    if (bus.flush) begin
      state_d   = ST_IDLE;
      to_cnt_d  = 8'd0;
      csr_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.lsu_vld_e) begin
            state_d    = ST_LS1;
            conflict_d = bus.csr_vld_e;
          end else if (bus.csr_vld_e) begin
            state_d   = ST_CSR;
            csr_cnt_d = CSR_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LS1: begin
          if (bus.lsu_except_ale_ls1) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_ALE;
          end else if (bus.lsu_except_buserr_ls3) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_BUSERR;
          end else if (bus.lsu_except_ecc_ls3) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_ECC;
          end else if (cmpl_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_WAIT;
            to_cnt_d = 8'd0;
          end
        end
        ST_WAIT: begin
          // Alignment faults are only meaningful in LS1 and are ignored here.
          if (bus.lsu_except_buserr_ls3) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_BUSERR;
          end else if (bus.lsu_except_ecc_ls3) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_ECC;
          end else if (cmpl_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            exc_d   = 1'b1;
            code_d  = CODE_TMO;
          end else if (to_cnt_q != 8'hFF) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end else begin
            to_cnt_d = to_cnt_q;
          end
        end
        ST_CSR: begin
          if (csr_cnt_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            csr_cnt_d = csr_cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    stall_d = (state_d != ST_IDLE);
    busy_d  = (state_d == ST_LS1) || (state_d == ST_WAIT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= 8'd0;
      csr_cnt_q  <= 2'd0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      exc_q      <= 1'b0;
      code_q     <= 2'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      csr_cnt_q  <= csr_cnt_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
      code_q     <= code_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.stall        = stall_q;
  assign bus.lsu_busy     = busy_q;
  assign bus.lsu_done     = done_q;
  assign bus.except_vld   = exc_q;
  assign bus.except_code  = code_q;
  assign bus.req_conflict = conflict_q;

endmodule

// File: tb/tb_c7bexu_lsu_ctl.sv
// Directed bench for c7bexu_lsu_ctl: stimulus pushes expected pulses into a scoreboard
// queue, a negedge monitor pops and compares them; level outputs are checked inline.
module tb_c7bexu_lsu_ctl;

  typedef struct {
    logic [1:0] kind;   // 0 done, 1 exception, 2 conflict
    logic [1:0] code;
  } exp_t;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  c7bexu_lsu_ctl_if bus_if ();

  c7bexu_lsu_ctl #(.TIMEOUT(4), .CSR_STALL(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [1:0] code);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d code %0d expected none at %0t", kind, code, $time);
    end else begin
      e = sb_q.pop_front();
      chk("pulse_kind", {6'd0, kind}, {6'd0, e.kind});
      if (kind == 2'd1) chk("except_code", {6'd0, code}, {6'd0, e.code});
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_if.lsu_done && bus_if.except_vld)
      chk("done_and_except", 8'd1, 8'd0);
    if (bus_if.req_conflict) pop_cmp(2'd2, 2'd0);
    if (bus_if.lsu_done)     pop_cmp(2'd0, 2'd0);
    if (bus_if.except_vld)   pop_cmp(2'd1, bus_if.except_code);
  end

  task automatic expect_pulse(input logic [1:0] kind, input logic [1:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in();
    bus_if.flush                 = 1'b0;
    bus_if.lsu_vld_e             = 1'b0;
    bus_if.csr_vld_e             = 1'b0;
    bus_if.lsu_except_ale_ls1    = 1'b0;
    bus_if.lsu_except_buserr_ls3 = 1'b0;
    bus_if.lsu_except_ecc_ls3    = 1'b0;
    bus_if.lsu_data_valid_ls3    = 1'b0;
    bus_if.lsu_wr_fin_ls3        = 1'b0;
  endtask

  task automatic chk_lvl(input string name, input logic stall, input logic busy);
    chk({name, "_stall"}, {7'd0, bus_if.stall}, {7'd0, stall});
    chk({name, "_busy"},  {7'd0, bus_if.lsu_busy}, {7'd0, busy});
  endtask

  task automatic start_lsu();
    bus_if.lsu_vld_e = 1'b1;
    cyc(1);
    bus_if.lsu_vld_e = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr_in();
    resetn = 1'b0;
    cyc(3);
    chk_lvl("reset", 1'b0, 1'b0);
    chk("reset_pulses", {5'd0, bus_if.lsu_done, bus_if.except_vld, bus_if.req_conflict}, 8'd0);
    chk("reset_code", {6'd0, bus_if.except_code}, 8'd0);
    resetn = 1'b1;

    // Idle
    cyc(1);
    chk_lvl("idle0", 1'b0, 1'b0);
    cyc(1);
    chk_lvl("idle1", 1'b0, 1'b0);

    // CSR stall for exactly two cycles
    bus_if.csr_vld_e = 1'b1;
    cyc(1);
    bus_if.csr_vld_e = 1'b0;
    chk_lvl("csr_c1", 1'b1, 1'b0);
    cyc(1);
    chk_lvl("csr_c2", 1'b1, 1'b0);
    cyc(1);
    chk_lvl("csr_end", 1'b0, 1'b0);

    // Alignment exception in LS1
    start_lsu();
    chk_lvl("ls1", 1'b1, 1'b1);
    bus_if.lsu_except_ale_ls1 = 1'b1;
    expect_pulse(2'd1, 2'd0);
    cyc(1);
    clr_in();
    chk_lvl("ale_end", 1'b0, 1'b0);

    // Load completion in LS1
    start_lsu();
    bus_if.lsu_data_valid_ls3 = 1'b1;
    expect_pulse(2'd0, 2'd0);
    cyc(1);
    clr_in();
    chk_lvl("dv_end", 1'b0, 1'b0);

    // Bus error beats data_valid
    start_lsu();
    bus_if.lsu_except_buserr_ls3 = 1'b1;
    bus_if.lsu_data_valid_ls3    = 1'b1;
    expect_pulse(2'd1, 2'd1);
    cyc(1);
    clr_in();

    // ECC beats store finish in LS1
    start_lsu();
    bus_if.lsu_except_ecc_ls3 = 1'b1;
    bus_if.lsu_wr_fin_ls3     = 1'b1;
    expect_pulse(2'd1, 2'd2);
    cyc(1);
    clr_in();

    // Timeout: LS1 then four WAIT cycles
    start_lsu();
    cyc(1);
    chk_lvl("wait0", 1'b1, 1'b1);
    cyc(3);
    chk_lvl("wait3", 1'b1, 1'b1);
    expect_pulse(2'd1, 2'd3);
    cyc(1);
    chk_lvl("tmo_end", 1'b0, 1'b0);

    // In WAIT: alignment ignored, then ECC beats data_valid
    start_lsu();
    cyc(1);
    bus_if.lsu_except_ale_ls1 = 1'b1;
    cyc(1);
    bus_if.lsu_except_ale_ls1 = 1'b0;
    chk_lvl("wait_ale_ign", 1'b1, 1'b1);
    bus_if.lsu_except_ecc_ls3 = 1'b1;
    bus_if.lsu_data_valid_ls3 = 1'b1;
    expect_pulse(2'd1, 2'd2);
    cyc(1);
    clr_in();

    // Store finish in WAIT
    start_lsu();
    cyc(2);
    bus_if.lsu_wr_fin_ls3 = 1'b1;
    expect_pulse(2'd0, 2'd0);
    cyc(1);
    clr_in();
    chk_lvl("wf_end", 1'b0, 1'b0);

    // Conflict: LSU wins, CSR dropped
    bus_if.lsu_vld_e = 1'b1;
    bus_if.csr_vld_e = 1'b1;
    expect_pulse(2'd2, 2'd0);
    cyc(1);
    clr_in();
    chk_lvl("conflict_ls1", 1'b1, 1'b1);
    bus_if.lsu_wr_fin_ls3 = 1'b1;
    expect_pulse(2'd0, 2'd0);
    cyc(1);
    clr_in();
    chk_lvl("conflict_end", 1'b0, 1'b0);

    // Flush in WAIT overrides a concurrent completion
    start_lsu();
    cyc(1);
    bus_if.flush              = 1'b1;
    bus_if.lsu_data_valid_ls3 = 1'b1;
    cyc(1);
    clr_in();
    chk_lvl("flush_wait", 1'b0, 1'b0);

    // Flush in IDLE blocks requests and the conflict pulse
    bus_if.flush     = 1'b1;
    bus_if.lsu_vld_e = 1'b1;
    bus_if.csr_vld_e = 1'b1;
    cyc(1);
    clr_in();
    chk_lvl("flush_idle", 1'b0, 1'b0);

    // LS3 events in IDLE and CSR are ignored
    bus_if.lsu_data_valid_ls3    = 1'b1;
    bus_if.lsu_except_buserr_ls3 = 1'b1;
    cyc(1);
    clr_in();
    bus_if.csr_vld_e = 1'b1;
    cyc(1);
    clr_in();
    bus_if.lsu_wr_fin_ls3     = 1'b1;
    bus_if.lsu_except_ecc_ls3 = 1'b1;
    cyc(1);
    clr_in();
    chk_lvl("csr_ls3_ign", 1'b1, 1'b0);
    cyc(1);
    chk_lvl("csr_ls3_end", 1'b0, 1'b0);

    // Asynchronous reset in WAIT
    start_lsu();
    cyc(1);
    #2;
    resetn = 1'b0;
    #1;
    chk_lvl("arst", 1'b0, 1'b0);
    chk("arst_pulses", {5'd0, bus_if.lsu_done, bus_if.except_vld, bus_if.req_conflict}, 8'd0);
    chk("arst_code", {6'd0, bus_if.except_code}, 8'd0);
    cyc(1);
    bus_if.lsu_data_valid_ls3 = 1'b1;
    resetn = 1'b1;
    cyc(1);
    clr_in();
    chk_lvl("post_rst", 1'b0, 1'b0);

    cyc(3);
    chk("sb_empty", 8'(sb_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c7bexu_lsu_ctl.md
C7BEXU_LSU_CTL -- requirements
Module: c7bexu_lsu_ctl

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT, 255, WAIT-state cycles before an LSU timeout exception (1..255).
- CSR_STALL, 2, stall cycles for a CSR op (1..3).

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  kill current operation.
- lsu_vld_e  in  1  LSU op valid in E.
- csr_vld_e  in  1  CSR op valid in E.
- lsu_except_ale_ls1  in  1  alignment exception, LS1.
- lsu_except_buserr_ls3  in  1  bus error, LS3.
- lsu_except_ecc_ls3  in  1  ECC error, LS3.
- lsu_data_valid_ls3  in  1  load data returned.
- lsu_wr_fin_ls3  in  1  store finished.
- stall  out  1  hold upstream pipeline.
- lsu_busy  out  1  LSU op outstanding.
- lsu_done  out  1  one-cycle pulse on normal LSU completion.
- except_vld  out  1  one-cycle pulse on LSU exception.
- except_code  out  2  0 ale, 1 buserr, 2 ecc, 3 timeout; valid only with except_vld.
- req_conflict  out  1  one-cycle pulse when lsu_vld_e and csr_vld_e are both high in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, LS1, WAIT, CSR.
REQ-004 In IDLE with lsu_vld_e=1, next state SHALL be LS1; otherwise, with csr_vld_e=1, next state SHALL be CSR and the CSR counter SHALL load CSR_STALL-1.
REQ-005 If both are high in IDLE, LSU SHALL win, the CSR request SHALL be dropped, and req_conflict SHALL pulse the next cycle.
REQ-006 lsu_vld_e and csr_vld_e SHALL be ignored outside IDLE.
REQ-007 Outputs SHALL be Moore:
- stall = (state != IDLE).
- lsu_busy = state in {LS1, WAIT}.
REQ-008 In LS1, resolution SHALL use the fixed priority ale > buserr > ecc > completion (data_valid or wr_fin); with no event, next state SHALL be WAIT.
REQ-009 In WAIT, priority SHALL be buserr > ecc > completion > timeout; lsu_except_ale_ls1 SHALL be ignored.
REQ-010 An exception event SHALL:
- return the FSM to IDLE;
- pulse except_vld for exactly one cycle, registered in the cycle state becomes IDLE;
- drive except_code with the winning code.
REQ-011 A completion event SHALL return the FSM to IDLE and pulse lsu_done for one cycle, aligned the same way; lsu_done and except_vld SHALL never be high together.
REQ-012 Timeout counter (8 bits):
- SHALL clear on entry to WAIT and increment each WAIT cycle without another event.
- When the count equals TIMEOUT-1 with no event, the FSM SHALL take the timeout exception (code 3).
- The counter SHALL saturate and never wrap.
REQ-013 In CSR, the counter SHALL decrement each cycle; at 0 the next state SHALL be IDLE, so stall is high for exactly CSR_STALL cycles.
REQ-014 flush=1 SHALL force next state IDLE from any state with no lsu_done and no except_vld, and SHALL override every concurrent event, including in IDLE.
REQ-015 LS3 events seen in IDLE or CSR SHALL be ignored and SHALL produce no pulse.

Reset
REQ-016 resetn=0 SHALL asynchronously force:
- state IDLE;
- both counters 0;
- stall, lsu_busy, lsu_done, except_vld, req_conflict = 0;
- except_code = 0.
REQ-017 Reset asserted mid-operation SHALL abandon the operation without any pulse; the first cycle after deassertion SHALL behave as IDLE.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Idle, all inputs 0 for 2 cycles -> stall=0, lsu_busy=0.
- csr_vld_e for 1 cycle, CSR_STALL=2 -> stall=1 for exactly 2 cycles, then 0.
- lsu_vld_e, then lsu_except_ale_ls1 next cycle -> except_vld pulse with code 0; stall=0 one cycle later.
- lsu_vld_e, then lsu_data_valid_ls3 next cycle -> lsu_done pulse, stall=0; with buserr and data_valid together -> except_vld with code 1, no lsu_done.
- lsu_vld_e with no response, TIMEOUT=4 -> LS1 plus 4 WAIT cycles, then except_vld with code 3 and stall=0.
- lsu_vld_e and csr_vld_e together -> req_conflict pulse and LSU path taken; a separate run with flush during WAIT -> IDLE, no pulses; a separate run with resetn=0 during WAIT -> all outputs 0 immediately.
